// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and widths for the two-requester memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    // One state per bus phase. TW repeats for the configured number of wait cycles.
    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3,
        DONE
    } bus_state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Round-robin selector: picks the first requester after the last one granted.
// If nobody has been granted yet, the search starts at requester 0.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] last_gnt,
    output logic [NREQ-1:0] gnt
);

    int   last_idx;
    logic found;

    // Walk the requesters cyclically, starting one past the last grant; take the first active one.
    always_comb begin
        last_idx = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            if (last_gnt[i]) begin
                last_idx = i;
            end
        end
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (j == ((last_idx + k) % NREQ)) && req[j]) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: grants one requester at a time and runs a
// T1/T2/(TW...)/T3/DONE bus cycle with active-low strobes.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int NREQ        = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req,
    input  logic [NREQ-1:0]                req_we,
    input  logic [NREQ-1:0][ADDR_W-1:0]    req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]    req_wdata,
    output logic [NREQ-1:0]                gnt,
    output logic [NREQ-1:0]                done,
    output logic [DATA_W-1:0]              rdata,
    output logic                           MREQ_L,
    output logic                           RD_L,
    output logic                           WR_L,
    output logic [ADDR_W-1:0]              addr_out,
    output logic [DATA_W-1:0]              dout,
    output logic                           dout_en,
    input  logic [DATA_W-1:0]              din
);

    // Last wait-cycle index; only meaningful when wait states are configured.
    localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    // Pretend the highest requester was granted last so requester 0 wins first after reset.
    localparam logic [NREQ-1:0] RR_RESET = NREQ'(1) << (NREQ - 1);

    bus_state_t        state;
    bus_state_t        next_state;
    logic [NREQ-1:0]   owner;
    logic [NREQ-1:0]   last_gnt;
    logic [NREQ-1:0]   arb_gnt;
    logic              we_q;
    logic [2:0]        wait_cnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt      (arb_gnt)
    );

    // Route the winning requester's direction, address and data toward the latch.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i];
                sel_wdata = req_wdata[i];
            end
        end
    end

    // Bus phase sequencing; TW is skipped entirely when no wait states are configured.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|req) next_state = T1;
            T1:      next_state = T2;
            T2:      next_state = (WAIT_STATES > 0) ? TW : T3;
            TW:      if (wait_cnt == WS_LAST) next_state = T3;
            T3:      next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes, grant and done decoded from the current phase and latched direction.
    always_comb begin
        MREQ_L  = 1'b1;
        RD_L    = 1'b1;
        WR_L    = 1'b1;
        dout_en = 1'b0;
        gnt     = '0;
        done    = '0;
        case (state)
            T1: begin
                MREQ_L = 1'b0;
                gnt    = owner;
            end
            T2, TW, T3: begin
                MREQ_L  = 1'b0;
                gnt     = owner;
                RD_L    = we_q;
                WR_L    = ~we_q;
                dout_en = we_q;
            end
            DONE: begin
                done = owner;
            end
            default: begin
            end
        endcase
    end

    // Phase register and wait counter; reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == TW) ? wait_cnt + 3'd1 : 3'd0;
        end
    end

    // Transaction latch on grant, and read data capture at the close of T3.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= '0;
            last_gnt <= RR_RESET;
            we_q     <= 1'b0;
            addr_out <= '0;
            dout     <= '0;
            rdata    <= '0;
        end else begin
            if (state == IDLE && |req) begin
                owner    <= arb_gnt;
                last_gnt <= arb_gnt;
                we_q     <= sel_we;
                addr_out <= sel_addr;
                if (sel_we) begin
                    dout <= sel_wdata;
                end
            end
            if (state == T3 && !we_q) begin
                rdata <= din;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model of arbitration and memory.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int NREQ    = 2;
    localparam int WS_LONG = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Zero-wait-state instance
    logic [NREQ-1:0]             req, req_we, gnt, done;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]           rdata, dout, din;
    logic                        mreq_l, rd_l, wr_l, dout_en;
    logic [ADDR_W-1:0]           addr_out;

    // Three-wait-state instance
    logic [NREQ-1:0]             req_w, req_we_w, gnt_w, done_w;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr_w;
    logic [NREQ-1:0][DATA_W-1:0] req_wdata_w;
    logic [DATA_W-1:0]           rdata_w, dout_w, din_w;
    logic                        mreq_l_w, rd_l_w, wr_l_w, dout_en_w;
    logic [ADDR_W-1:0]           addr_out_w;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory device on the bus, and the bench's own view of what it should hold
    logic [7:0] dev_mem [0:255];
    logic [7:0] ref_mem [0:255];

    mem_bus_arbiter #(.WAIT_STATES(0), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata),
        .MREQ_L(mreq_l), .RD_L(rd_l), .WR_L(wr_l), .addr_out(addr_out),
        .dout(dout), .dout_en(dout_en), .din(din)
    );

    mem_bus_arbiter #(.WAIT_STATES(WS_LONG), .NREQ(NREQ)) dut_ws (
        .clk(clk), .rst(rst), .req(req_w), .req_we(req_we_w), .req_addr(req_addr_w),
        .req_wdata(req_wdata_w), .gnt(gnt_w), .done(done_w), .rdata(rdata_w),
        .MREQ_L(mreq_l_w), .RD_L(rd_l_w), .WR_L(wr_l_w), .addr_out(addr_out_w),
        .dout(dout_w), .dout_en(dout_en_w), .din(din_w)
    );

    assign din   = dev_mem[addr_out[7:0]];
    assign din_w = addr_out_w[7:0] ^ 8'h5A;

    always @(posedge clk) begin
        if (!wr_l && dout_en) dev_mem[addr_out[7:0]] = dout;
    end

    typedef struct packed {
        logic [NREQ-1:0]   gnt;
        logic [NREQ-1:0]   done;
        logic              mreq_l;
        logic              rd_l;
        logic              wr_l;
        logic              dout_en;
        logic [ADDR_W-1:0] addr;
    } snap_t;

    snap_t tr[$];

    logic              m_we    [NREQ];
    logic [ADDR_W-1:0] m_addr  [NREQ];
    logic [DATA_W-1:0] m_wdata [NREQ];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic record(input int n, input bit drop_on_done);
        tr.delete();
        for (int i = 0; i < n; i++) begin
            tick();
            tr.push_back('{gnt: gnt, done: done, mreq_l: mreq_l, rd_l: rd_l,
                           wr_l: wr_l, dout_en: dout_en, addr: addr_out});
            if (drop_on_done) req = req & ~done;
        end
    endtask

    function automatic int n_mreq();
        int c = 0;
        foreach (tr[i]) if (!tr[i].mreq_l) c++;
        return c;
    endfunction

    function automatic int n_rd();
        int c = 0;
        foreach (tr[i]) if (!tr[i].rd_l) c++;
        return c;
    endfunction

    function automatic int n_wr();
        int c = 0;
        foreach (tr[i]) if (!tr[i].wr_l) c++;
        return c;
    endfunction

    function automatic int n_den();
        int c = 0;
        foreach (tr[i]) if (tr[i].dout_en) c++;
        return c;
    endfunction

    function automatic int n_den_bad();
        int c = 0;
        foreach (tr[i]) if (tr[i].dout_en && tr[i].wr_l) c++;
        return c;
    endfunction

    function automatic int first_done();
        for (int i = 0; i < tr.size(); i++) if (tr[i].done != '0) return i;
        return -1;
    endfunction

    task automatic drain();
        req = '0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({mreq_l, rd_l, wr_l} !== 3'b111) $display("[TB] FAIL reset_strobes: got %b expected 111", {mreq_l, rd_l, wr_l});
        else n_pass++;
        n_checks++;
        if ({dout_en, gnt, done} !== 5'b0) $display("[TB] FAIL reset_ctrl: got %b expected 00000", {dout_en, gnt, done});
        else n_pass++;
        n_checks++;
        if (rdata !== 8'h00) $display("[TB] FAIL reset_rdata: got %h expected 00", rdata);
        else n_pass++;
        n_checks++;
        if (addr_out !== 16'h0000) $display("[TB] FAIL reset_addr: got %h expected 0000", addr_out);
        else n_pass++;
        n_checks++;
        if (dout !== 8'h00) $display("[TB] FAIL reset_dout: got %h expected 00", dout);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        dev_mem[0] = 8'h2A;
        ref_mem[0] = 8'h2A;
        req_we[0] = 1'b0;
        req_addr[0] = 16'h0000;
        req[0] = 1'b1;
        record(6, 1'b1);
        n_checks++;
        if (tr[0].gnt !== 2'b01) $display("[TB] FAIL read_grant: got %b expected 01", tr[0].gnt);
        else n_pass++;
        n_checks++;
        if (n_rd() !== 2 || n_mreq() !== 3) $display("[TB] FAIL read_strobes: got rd=%0d mreq=%0d expected rd=2 mreq=3", n_rd(), n_mreq());
        else n_pass++;
        n_checks++;
        if (first_done() !== 3 || tr[3].done !== 2'b01) $display("[TB] FAIL read_done: got idx %0d val %b expected idx 3 val 01", first_done(), tr[3].done);
        else n_pass++;
        n_checks++;
        if (rdata !== 8'h2A) $display("[TB] FAIL read_data: got %h expected 2a", rdata);
        else n_pass++;
    endtask

    task automatic test_single_write();
        req_we[1] = 1'b1;
        req_addr[1] = 16'h00BB;
        req_wdata[1] = 8'hCC;
        req[1] = 1'b1;
        record(6, 1'b1);
        ref_mem[8'hBB] = 8'hCC;
        n_checks++;
        if (tr[0].gnt !== 2'b10 || tr[0].addr !== 16'h00BB) $display("[TB] FAIL write_grant: got gnt %b addr %h expected 10 00bb", tr[0].gnt, tr[0].addr);
        else n_pass++;
        n_checks++;
        if (n_wr() !== 2 || n_den() !== 2 || n_rd() !== 0) $display("[TB] FAIL write_strobes: got wr=%0d den=%0d rd=%0d expected 2 2 0", n_wr(), n_den(), n_rd());
        else n_pass++;
        n_checks++;
        if (n_den_bad() !== 0) $display("[TB] FAIL write_den_window: got %0d stray cycles expected 0", n_den_bad());
        else n_pass++;
        n_checks++;
        if (first_done() !== 3 || tr[3].done !== 2'b10) $display("[TB] FAIL write_done: got idx %0d val %b expected idx 3 val 10", first_done(), tr[3].done);
        else n_pass++;
        n_checks++;
        if (dout !== 8'hCC) $display("[TB] FAIL write_dout: got %h expected cc", dout);
        else n_pass++;
        req_we[0] = 1'b0;
        req_addr[0] = 16'h00BB;
        req[0] = 1'b1;
        record(6, 1'b1);
        n_checks++;
        if (rdata !== 8'hCC) $display("[TB] FAIL write_readback: got %h expected cc", rdata);
        else n_pass++;
    endtask

    task automatic test_request_drop();
        req_we[0] = 1'b0;
        req_addr[0] = 16'h0003;
        req[0] = 1'b1;
        tick();
        n_checks++;
        if (gnt !== 2'b01) $display("[TB] FAIL drop_grant: got %b expected 01", gnt);
        else n_pass++;
        req[0] = 1'b0;
        record(5, 1'b0);
        n_checks++;
        if (first_done() !== 2 || tr[2].done !== 2'b01) $display("[TB] FAIL drop_done: got idx %0d val %b expected idx 2 val 01", first_done(), tr[2].done);
        else n_pass++;
        n_checks++;
        if (tr[3].gnt !== 2'b00 || tr[4].gnt !== 2'b00) $display("[TB] FAIL drop_no_regrant: got %b %b expected 00 00", tr[3].gnt, tr[4].gnt);
        else n_pass++;
        n_checks++;
        if (rdata !== ref_mem[3]) $display("[TB] FAIL drop_rdata: got %h expected %h", rdata, ref_mem[3]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        req_we[1] = 1'b1;
        req_addr[1] = 16'h0080;
        req_wdata[1] = 8'h77;
        req[1] = 1'b1;
        tick();
        tick();
        n_checks++;
        if (wr_l !== 1'b0 || gnt !== 2'b10) $display("[TB] FAIL midrst_in_t2: got wr_l %b gnt %b expected 0 10", wr_l, gnt);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({mreq_l, rd_l, wr_l} !== 3'b111) $display("[TB] FAIL midrst_strobes: got %b expected 111", {mreq_l, rd_l, wr_l});
        else n_pass++;
        n_checks++;
        if ({gnt, done, dout_en} !== 5'b0) $display("[TB] FAIL midrst_ctrl: got %b expected 00000", {gnt, done, dout_en});
        else n_pass++;
        req[1] = 1'b0;
        rst = 1'b0;
        record(6, 1'b0);
        n_checks++;
        if (first_done() !== -1) $display("[TB] FAIL midrst_no_done: got done at %0d expected none", first_done());
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] exp_g;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_we = '0;
        req_addr[0] = 16'h0001;
        req_addr[1] = 16'h0002;
        req = 2'b11;
        record(20, 1'b0);
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++;
            if (tr[k * 5].gnt !== exp_g) $display("[TB] FAIL contention_grant%0d: got %b expected %b", k, tr[k * 5].gnt, exp_g);
            else n_pass++;
        end
        n_checks++;
        if (tr[3].done !== 2'b01 || tr[8].done !== 2'b10) $display("[TB] FAIL contention_done: got %b %b expected 01 10", tr[3].done, tr[8].done);
        else n_pass++;
        n_checks++;
        if (tr[4].gnt !== 2'b00 || tr[4].mreq_l !== 1'b1 || tr[9].gnt !== 2'b00 || tr[9].mreq_l !== 1'b1)
            $display("[TB] FAIL contention_idle_gap: got gnt %b/%b mreq_l %b/%b expected 00/00 1/1", tr[4].gnt, tr[9].gnt, tr[4].mreq_l, tr[9].mreq_l);
        else n_pass++;
        drain();
    endtask

    task automatic test_wait_states();
        int mreq_cnt = 0;
        int rd_cnt   = 0;
        int done_at  = -1;
        logic [NREQ-1:0] gnt_first = '0;
        logic [NREQ-1:0] done_val  = '0;
        req_we_w = '0;
        req_wdata_w = '0;
        req_addr_w[0] = 16'h0033;
        req_addr_w[1] = 16'h0000;
        req_w = 2'b01;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) gnt_first = gnt_w;
            if (!mreq_l_w) mreq_cnt++;
            if (!rd_l_w) rd_cnt++;
            if (done_w != '0 && done_at < 0) begin
                done_at  = i;
                done_val = done_w;
                req_w    = '0;
            end
        end
        n_checks++;
        if (gnt_first !== 2'b01) $display("[TB] FAIL ws_grant: got %b expected 01", gnt_first);
        else n_pass++;
        n_checks++;
        if (mreq_cnt !== 3 + WS_LONG || rd_cnt !== 2 + WS_LONG) $display("[TB] FAIL ws_strobes: got mreq=%0d rd=%0d expected %0d %0d", mreq_cnt, rd_cnt, 3 + WS_LONG, 2 + WS_LONG);
        else n_pass++;
        n_checks++;
        if (done_at !== 3 + WS_LONG || done_val !== 2'b01) $display("[TB] FAIL ws_done: got idx %0d val %b expected idx %0d val 01", done_at, done_val, 3 + WS_LONG);
        else n_pass++;
        n_checks++;
        if (rdata_w !== (8'h33 ^ 8'h5A)) $display("[TB] FAIL ws_rdata: got %h expected %h", rdata_w, 8'h33 ^ 8'h5A);
        else n_pass++;
    endtask

    task automatic new_request(input int i);
        m_we[i]      = 1'($urandom_range(0, 1));
        m_addr[i]    = 16'($urandom_range(0, 15));
        m_wdata[i]   = 8'($urandom);
        req_we[i]    = m_we[i];
        req_addr[i]  = m_addr[i];
        req_wdata[i] = m_wdata[i];
        req[i]       = 1'b1;
    endtask

    task automatic test_random_traffic();
        int last_owner = NREQ - 1;
        int win;
        int n;
        logic [NREQ-1:0] exp_g;
        logic [DATA_W-1:0] exp_rdata = 8'h00;
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) new_request(i);
            end
            if (req == '0) new_request($urandom_range(0, NREQ - 1));
            if (req[0] && req[1]) win = (last_owner == 0) ? 1 : 0;
            else win = req[0] ? 0 : 1;
            exp_g = '0;
            exp_g[win] = 1'b1;
            n = 0;
            while (gnt == '0 && n < 8) begin
                tick();
                n++;
            end
            n_checks++;
            if (gnt !== exp_g || addr_out !== m_addr[win])
                $display("[TB] FAIL rand%0d_grant: got gnt %b addr %h expected %b %h", r, gnt, addr_out, exp_g, m_addr[win]);
            else n_pass++;
            req_addr[win]  = 16'($urandom);
            req_wdata[win] = 8'($urandom);
            req_we[win]    = ~req_we[win];
            n = 0;
            while (done == '0 && n < 12) begin
                tick();
                n++;
            end
            n_checks++;
            if (n !== 3 || done !== exp_g) $display("[TB] FAIL rand%0d_done: got %0d cycles val %b expected 3 %b", r, n, done, exp_g);
            else n_pass++;
            if (m_we[win]) begin
                ref_mem[m_addr[win][7:0]] = m_wdata[win];
                n_checks++;
                if (dout !== m_wdata[win]) $display("[TB] FAIL rand%0d_dout: got %h expected %h", r, dout, m_wdata[win]);
                else n_pass++;
            end else begin
                exp_rdata = ref_mem[m_addr[win][7:0]];
            end
            n_checks++;
            if (rdata !== exp_rdata) $display("[TB] FAIL rand%0d_rdata: got %h expected %h", r, rdata, exp_rdata);
            else n_pass++;
            last_owner = win;
            req[win] = 1'b0;
        end
        drain();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        req_w = '0; req_we_w = '0; req_addr_w = '0; req_wdata_w = '0;
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        test_reset();
        test_single_read();
        test_single_write();
        test_request_drop();
        test_reset_mid_op();
        test_contention();
        test_wait_states();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 0: extra TW cycles inserted between T2 and T3 (range 0-7).
REQ-002 Parameter NREQ, default 2: number of requesters (index 0 = CPU, 1 = loader/DMA).
REQ-003 clk  in  1  single system clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req  in  NREQ  per-requester access request, level, held until matching done.
REQ-006 req_we  in  NREQ  per-requester write enable (1 = write, 0 = read), sampled with req.
REQ-007 req_addr  in  NREQ x 16  per-requester address.
REQ-008 req_wdata  in  NREQ x 8  per-requester write data.
REQ-009 gnt  out  NREQ  one-hot grant, high from T1 through T3 of the owning transaction.
REQ-010 done  out  NREQ  one-cycle pulse to the owner in the cycle after T3.
REQ-011 rdata  out  8  read data captured at end of T3; holds until the next read completes.
REQ-012 MREQ_L  out  1  active-low memory request strobe.
REQ-013 RD_L  out  1  active-low read strobe.
REQ-014 WR_L  out  1  active-low write strobe.
REQ-015 addr_out  out  16  memory address.
REQ-016 dout  out  8  write data toward the shared data bus.
REQ-017 dout_en  out  1  tristate enable for dout; high only while the transaction is a write and WR_L is low.
REQ-018 din  in  8  read data from the shared data bus.

Function
REQ-019 FSM states: IDLE, T1, T2, TW, T3, DONE; exactly one active at a time.
REQ-020 IDLE: if any req is high, arbitrate, latch owner/we/addr/wdata, go to T1; else remain in IDLE.
REQ-021 Arbitration is round-robin: on contention, the requester not granted last wins; on a single request, that requester wins.
REQ-022 T1: addr_out = latched address, MREQ_L = 0, RD_L = WR_L = 1, gnt[owner] = 1.
REQ-023 T2: MREQ_L = 0; RD_L = 0 for a read or WR_L = 0 with dout_en = 1 for a write; go to TW if WAIT_STATES > 0, else to T3.
REQ-024 TW: strobes held as in T2; a 3-bit counter runs for exactly WAIT_STATES cycles, then the FSM goes to T3.
REQ-025 T3: strobes held as in T2; for a read, rdata <= din at the end of T3.
REQ-026 DONE: all strobes are 1, dout_en = 0, gnt = 0, done[owner] = 1 for one cycle; the FSM then goes to IDLE.
REQ-027 Transaction length is 4 + WAIT_STATES cycles from T1 to DONE inclusive; back-to-back grants are separated by one IDLE cycle.
REQ-028 Latched address, write data and direction are stable from T1 to DONE; changes on req_* inputs mid-transaction are ignored.
REQ-029 Dropping req mid-transaction does not abort the transaction; done still pulses.
REQ-030 A requester whose req is still high in IDLE after its done is treated as a new request.
REQ-031 addr_out and dout hold their last values in IDLE; MREQ_L, RD_L and WR_L are 1 in IDLE.

Reset
REQ-032 rst = 1 forces IDLE with MREQ_L = RD_L = WR_L = 1, dout_en = 0, gnt = 0, done = 0, rdata = 0, addr_out = 0, dout = 0, and the round-robin pointer favouring requester 0.
REQ-033 Reset asserted mid-transaction takes effect on the next edge: strobes deassert, no done pulse is issued, and the in-flight transaction is discarded.

Structure
REQ-034 The shared package holds the FSM state enum (IDLE, T1, T2, TW, T3, DONE) and the constants ADDR_W = 16 and DATA_W = 8.
REQ-035 The round-robin selector is a sub-module, rr_arbiter, with inputs req and last-grant and a one-hot output.

Verification
REQ-036 Single read: req[0] = 1, addr 16'h0000, memory holding 8'h2A, WAIT_STATES = 0 -> RD_L low for 2 cycles, done[0] pulses 4 cycles after T1, rdata = 8'h2A.
REQ-037 Single write: req[1] = 1, we = 1, addr 16'h00BB, wdata 8'hCC -> WR_L and dout_en low/high for 2 cycles; a following read of 16'h00BB returns 8'hCC.
REQ-038 Contention: req = 2'b11 held continuously -> grants alternate 0, 1, 0, 1, each pair of grants separated by one IDLE cycle.
REQ-039 Wait states: WAIT_STATES = 3, single read -> MREQ_L low for 6 cycles, done 7 cycles after T1.
REQ-040 Reset mid-op: assert rst in T2 of a write -> next cycle all strobes are 1, gnt = 0, and done never pulses.
REQ-041 Request drop: deassert req[0] in T1 -> transaction completes and done[0] still pulses.
